// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub command sequencer slice:
// opcode encoding and default datapath width.
package addsub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_e;

endpackage

// File: rtl/addsub_cmd_sequencer_if.sv
// Command and result handshake bundle for addsub_cmd_sequencer.
// master = command producer / result consumer, slave = sequencer.
interface addsub_cmd_sequencer_if #(
    parameter int unsigned WIDTH = addsub_pkg::DEFAULT_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_ovf;

    modport master (
        output cmd_valid, cmd_op, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_cout, res_ovf
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_cout, res_ovf
    );
endinterface

// File: rtl/add_or_sub.sv
// Combinational WIDTH-bit adder/subtractor: a+b, or a+~b+1 when add_sub=1.
// cout is the raw carry out of the MSB (1 = no borrow on subtract);
// ovf is two's-complement overflow of the performed operation.
module add_or_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    // Invert B for subtract and inject the +1 as carry-in.
    always_comb begin
        b_eff    = add_sub ? ~b : b;
        full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_sub};
        sum      = full_sum[WIDTH-1:0];
        cout     = full_sum[WIDTH];
        ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

// File: rtl/addsub_cmd_fifo.sv
// Synchronous FIFO holding {op, data} command entries.
// Pointers and count reset asynchronously; storage is not reset.
module addsub_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Status flags and guarded push/pop strobes.
    always_comb begin
        full    = (count == CNT_FULL);
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem[rptr];
    end

    // Pointer and occupancy tracking; power-of-two depth wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/addsub_cmd_sequencer.sv
// Accumulator command sequencer: buffers LOAD/ADD/SUB/CLEAR commands,
// executes one per cycle through add_or_sub, and holds each result on a
// valid/ready port until consumed.
module addsub_cmd_sequencer
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    addsub_cmd_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]       acc_out,
    output logic                   busy
);
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [WIDTH+1:0]         head;
    logic                     push;
    logic                     exec;
    cmd_op_e                  head_op;
    logic [WIDTH-1:0]         head_data;

    logic [WIDTH-1:0]         acc;
    logic                     res_valid_q;
    logic [WIDTH-1:0]         res_data_q;
    logic                     res_cout_q;
    logic                     res_ovf_q;

    logic [WIDTH-1:0]         core_sum;
    logic                     core_cout;
    logic                     core_ovf;
    logic [WIDTH-1:0]         nxt_acc;
    logic                     nxt_cout;
    logic                     nxt_ovf;

    // Handshake, scheduling and status outputs.
    always_comb begin
        bus.cmd_ready = !fifo_full;
        push          = bus.cmd_valid && !fifo_full;
        exec          = !fifo_empty && (!res_valid_q || bus.res_ready);
        head_op       = cmd_op_e'(head[WIDTH+1:WIDTH]);
        head_data     = head[WIDTH-1:0];
        bus.res_valid = res_valid_q;
        bus.res_data  = res_data_q;
        bus.res_cout  = res_cout_q;
        bus.res_ovf   = res_ovf_q;
        acc_out       = acc;
        busy          = (fifo_count != '0) || res_valid_q;
    end

    addsub_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (exec),
        .wdata ({bus.cmd_op, bus.cmd_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    add_or_sub #(
        .WIDTH (WIDTH)
    ) u_core (
        .a       (acc),
        .b       (head_data),
        .add_sub (head_op == OP_SUB),
        .sum     (core_sum),
        .cout    (core_cout),
        .ovf     (core_ovf)
    );

    // Result of the head command; LOAD and CLEAR bypass the core flags.
    always_comb begin
        nxt_acc  = '0;
        nxt_cout = 1'b0;
        nxt_ovf  = 1'b0;
        case (head_op)
            OP_LOAD:  nxt_acc = head_data;
            OP_ADD,
            OP_SUB: begin
                nxt_acc  = core_sum;
                nxt_cout = core_cout;
                nxt_ovf  = core_ovf;
            end
            default:  nxt_acc = '0;
        endcase
    end

    // Accumulator and result register; execute takes priority over plain consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else if (exec) begin
            acc         <= nxt_acc;
            res_valid_q <= 1'b1;
            res_data_q  <= nxt_acc;
            res_cout_q  <= nxt_cout;
            res_ovf_q   <= nxt_ovf;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_cmd_sequencer.sv
// Directed bench for addsub_cmd_sequencer with hand-computed expectations.
module tb_addsub_cmd_sequencer;
    import addsub_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] acc_out;
    logic       busy;
    int         checks;
    int         fails;

    addsub_cmd_sequencer_if #(.WIDTH(4)) bus ();

    addsub_cmd_sequencer #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .acc_out (acc_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push two commands back to back with res_ready=1 and capture both results.
    // Called and returns at 1 time unit after a rising edge.
    task automatic send2(input logic [1:0] op1, input logic [3:0] d1,
                         input logic [1:0] op2, input logic [3:0] d2,
                         output logic [6:0] res1, output logic [6:0] res2,
                         output logic [3:0] acc1, output logic busy_end);
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op1;
        bus.cmd_data  = d1;
        @(posedge clk); #1;
        bus.cmd_op    = op2;
        bus.cmd_data  = d2;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        res1 = {bus.res_valid, bus.res_data, bus.res_cout, bus.res_ovf};
        acc1 = acc_out;
        @(posedge clk); #1;
        res2 = {bus.res_valid, bus.res_data, bus.res_cout, bus.res_ovf};
        @(posedge clk); #1;
        busy_end = busy;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_cout, bus.res_ovf} !== 7'b0_0000_0_0) begin
            fails++;
            $display("FAIL reset_res: got %b expected 0000000",
                     {bus.res_valid, bus.res_data, bus.res_cout, bus.res_ovf});
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
        checks++;
        if (acc_out !== 4'b0000) begin
            fails++; $display("FAIL reset_acc: got %b expected 0000", acc_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.cmd_ready, bus.res_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL post_reset_idle: got %b expected 100", {bus.cmd_ready, bus.res_valid, busy});
        end
    endtask

    task automatic test_add();
        logic [6:0] r1, r2;
        logic [3:0] a1;
        logic       b_end;
        send2(OP_LOAD, 4'b1100, OP_ADD, 4'b1111, r1, r2, a1, b_end);
        checks++;
        if (r1 !== 7'b1_1100_0_0) begin
            fails++; $display("FAIL add_first: got %b expected 1110000", r1);
        end
        checks++;
        if (a1 !== 4'b1100) begin
            fails++; $display("FAIL add_acc_tracks: got %b expected 1100", a1);
        end
        checks++;
        if (r2 !== 7'b1_1011_1_0) begin
            fails++; $display("FAIL add_second: got %b expected 1101110", r2);
        end
        checks++;
        if (b_end !== 1'b0) begin
            fails++; $display("FAIL add_idle: got busy %b expected 0", b_end);
        end
    endtask

    task automatic test_sub();
        logic [6:0] r1, r2;
        logic [3:0] a1;
        logic       b_end;
        send2(OP_LOAD, 4'b1111, OP_SUB, 4'b1100, r1, r2, a1, b_end);
        checks++;
        if (r2 !== 7'b1_0011_1_0) begin
            fails++; $display("FAIL sub_no_borrow: got %b expected 1001110", r2);
        end
        send2(OP_LOAD, 4'b1100, OP_SUB, 4'b1111, r1, r2, a1, b_end);
        checks++;
        if (r2 !== 7'b1_1101_0_0) begin
            fails++; $display("FAIL sub_borrow: got %b expected 1110100", r2);
        end
    endtask

    task automatic test_overflow();
        logic [6:0] r1, r2;
        logic [3:0] a1;
        logic       b_end;
        send2(OP_LOAD, 4'b0111, OP_ADD, 4'b0001, r1, r2, a1, b_end);
        checks++;
        if (r2 !== 7'b1_1000_0_1) begin
            fails++; $display("FAIL add_ovf: got %b expected 1100001", r2);
        end
        send2(OP_LOAD, 4'b1000, OP_SUB, 4'b0001, r1, r2, a1, b_end);
        checks++;
        if (r2 !== 7'b1_0111_1_1) begin
            fails++; $display("FAIL sub_ovf: got %b expected 1011111", r2);
        end
        // acc = 0111 here: 0111+0011 overflows, then CLEAR ignores its data
        send2(OP_ADD, 4'b0011, OP_CLEAR, 4'b0101, r1, r2, a1, b_end);
        checks++;
        if (r1 !== 7'b1_1010_0_1) begin
            fails++; $display("FAIL add_ovf2: got %b expected 1101001", r1);
        end
        checks++;
        if (r2 !== 7'b1_0000_0_0) begin
            fails++; $display("FAIL clear: got %b expected 1000000", r2);
        end
        checks++;
        if (acc_out !== 4'b0000) begin
            fails++; $display("FAIL clear_acc: got %b expected 0000", acc_out);
        end
    endtask

    task automatic test_backpressure();
        int   accepted;
        logic will_accept;
        int   n;
        int   got [6];
        int   gcyc [6];
        for (int i = 0; i < 6; i++) begin
            got[i]  = -1;
            gcyc[i] = -1;
        end
        accepted      = 0;
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 4'b0001;
        for (int cyc = 0; cyc < 8; cyc++) begin
            will_accept = bus.cmd_ready;
            @(posedge clk); #1;
            if (will_accept) begin
                accepted++;
                bus.cmd_op = OP_ADD;
            end
        end
        checks++;
        if (accepted !== 5) begin
            fails++; $display("FAIL bp_accepted: got %0d expected 5", accepted);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            fails++; $display("FAIL bp_full: got cmd_ready %b expected 0", bus.cmd_ready);
        end
        checks++;
        if ({bus.res_valid, bus.res_data, acc_out} !== 9'b1_0001_0001) begin
            fails++;
            $display("FAIL bp_held: got %b expected 100010001", {bus.res_valid, bus.res_data, acc_out});
        end
        bus.res_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (bus.res_valid && n < 6) begin
                got[n]  = int'(bus.res_data);
                gcyc[n] = cyc;
                n++;
            end
            will_accept = bus.cmd_valid && bus.cmd_ready;
            @(posedge clk); #1;
            if (will_accept) begin
                accepted++;
                bus.cmd_valid = 1'b0;
            end
        end
        checks++;
        if (n !== 6) begin
            fails++; $display("FAIL bp_count: got %0d results expected 6", n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== i + 1) begin
                fails++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got[i], i + 1);
            end
        end
        checks++;
        if (gcyc[4] - gcyc[0] !== 4) begin
            fails++; $display("FAIL bp_rate: got span %0d expected 4", gcyc[4] - gcyc[0]);
        end
        checks++;
        if (accepted !== 6) begin
            fails++; $display("FAIL bp_sixth: got %0d accepted expected 6", accepted);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL bp_drained: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_midop();
        logic [6:0] r1, r2;
        logic [3:0] a1;
        logic       b_end;
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            bus.cmd_op = (i == 0) ? OP_LOAD : OP_ADD;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.res_valid, busy, acc_out} !== 6'b11_0011) begin
            fails++; $display("FAIL midop_setup: got %b expected 110011", {bus.res_valid, busy, acc_out});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.res_valid, busy, bus.cmd_ready} !== 3'b001) begin
            fails++;
            $display("FAIL midop_reset_flags: got %b expected 001", {bus.res_valid, busy, bus.cmd_ready});
        end
        checks++;
        if (acc_out !== 4'b0000) begin
            fails++; $display("FAIL midop_reset_acc: got %b expected 0000", acc_out);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        send2(OP_LOAD, 4'b0101, OP_ADD, 4'b0000, r1, r2, a1, b_end);
        checks++;
        if (r1 !== 7'b1_0101_0_0) begin
            fails++; $display("FAIL midop_after: got %b expected 1010100", r1);
        end
        checks++;
        if (b_end !== 1'b0) begin
            fails++; $display("FAIL midop_after_idle: got busy %b expected 0", b_end);
        end
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 4'b0000;
        bus.res_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
